// File: rtl/dcache_if.sv
// CPU-side and memory-side signal bundle of the L1 data cache controller.
// The controller connects through the slave modport; the CPU/memory environment uses master.
interface dcache_if #(
    parameter int ADDR_W    = 32,
    parameter int LINE_BITS = 256
);
    logic                 cpu_req_i;
    logic                 cpu_we_i;
    logic [ADDR_W-1:0]    cpu_addr_i;
    logic [31:0]          cpu_wdata_i;
    logic [31:0]          cpu_rdata_o;
    logic                 cpu_stall_o;
    logic                 mem_req_o;
    logic                 mem_we_o;
    logic [ADDR_W-1:0]    mem_addr_o;
    logic [LINE_BITS-1:0] mem_wdata_o;
    logic [LINE_BITS-1:0] mem_rdata_i;
    logic                 mem_ack_i;

    modport slave (
        input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i, mem_rdata_i, mem_ack_i,
        output cpu_rdata_o, cpu_stall_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
    );

    modport master (
        output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i, mem_rdata_i, mem_ack_i,
        input  cpu_rdata_o, cpu_stall_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
    );
endinterface

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate L1 data cache controller.
// Hits complete in the request cycle; misses stall the pipeline while a line is written back and/or filled.
module dcache_ctrl #(
    parameter int NUM_LINES = 16,
    parameter int LINE_BITS = 256,
    parameter int ADDR_W    = 32
) (
    input logic     clk_i,
    input logic     rst_i,
    dcache_if.slave bus
);
    localparam int WORDS   = LINE_BITS / 32;
    localparam int WORD_W  = $clog2(WORDS);
    localparam int OFFS_W  = $clog2(LINE_BITS / 8);
    localparam int INDEX_W = $clog2(NUM_LINES);
    localparam int TAG_W   = ADDR_W - INDEX_W - OFFS_W;

    typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_t;

    state_t state_q, state_n;

    logic [NUM_LINES-1:0] valid_q;
    logic [NUM_LINES-1:0] dirty_q;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [LINE_BITS-1:0] data_q [NUM_LINES];

    logic                 mem_req_q;
    logic                 mem_we_q;
    logic [ADDR_W-1:0]    mem_addr_q;
    logic [LINE_BITS-1:0] mem_wdata_q;

    logic [WORD_W-1:0]  word;
    logic [INDEX_W-1:0] index;
    logic [TAG_W-1:0]   req_tag;
    logic               unused_addr_lsb;
    logic               hit, miss, in_idle, read_hit, write_hit, fill_done, stall;

    function automatic logic [31:0] get_word(input logic [LINE_BITS-1:0] line,
                                             input logic [WORD_W-1:0] w);
        return line[{w, 5'b0} +: 32];
    endfunction

    assign word            = bus.cpu_addr_i[OFFS_W-1:2];
    assign index           = bus.cpu_addr_i[OFFS_W +: INDEX_W];
    assign req_tag         = bus.cpu_addr_i[ADDR_W-1 -: TAG_W];
    assign unused_addr_lsb = ^bus.cpu_addr_i[1:0];

    assign hit       = bus.cpu_req_i & valid_q[index] & (tag_q[index] == req_tag);
    assign miss      = bus.cpu_req_i & ~hit;
    assign in_idle   = (state_q == IDLE);
    assign read_hit  = in_idle & hit & ~bus.cpu_we_i;
    assign write_hit = in_idle & hit & bus.cpu_we_i;
    assign fill_done = (state_q == ALLOCATE) & bus.mem_ack_i;

    always_comb begin
        state_n = state_q;
        stall   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (miss) begin
                    stall   = 1'b1;
                    state_n = (valid_q[index] && dirty_q[index]) ? WRITEBACK : ALLOCATE;
                end
            end
            WRITEBACK: begin
                stall = 1'b1;
                if (bus.mem_ack_i) state_n = ALLOCATE;
            end
            ALLOCATE: begin
                stall = 1'b1;
                if (bus.mem_ack_i) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Memory request fields are latched on entry to a transfer state so they stay
    // stable through the ack cycle regardless of what the array read ports do.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            valid_q    <= '0;
            dirty_q    <= '0;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
        end else begin
            state_q <= state_n;
            if (write_hit) dirty_q[index] <= 1'b1;
            if (fill_done) begin
                valid_q[index] <= 1'b1;
                dirty_q[index] <= 1'b0;
            end
            if (in_idle && state_n == WRITEBACK) begin
                mem_req_q  <= 1'b1;
                mem_we_q   <= 1'b1;
                mem_addr_q <= {tag_q[index], index, {OFFS_W{1'b0}}};
            end else if (state_q != ALLOCATE && state_n == ALLOCATE) begin
                mem_req_q  <= 1'b1;
                mem_we_q   <= 1'b0;
                mem_addr_q <= {req_tag, index, {OFFS_W{1'b0}}};
            end else if (fill_done) begin
                mem_req_q <= 1'b0;
                mem_we_q  <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (in_idle && state_n == WRITEBACK) mem_wdata_q <= data_q[index];
        if (!rst_i && fill_done) begin
            tag_q[index]  <= req_tag;
            data_q[index] <= bus.mem_rdata_i;
        end else if (!rst_i && write_hit) begin
            data_q[index][{word, 5'b0} +: 32] <= bus.cpu_wdata_i;
        end
    end

    assign bus.cpu_stall_o = stall & ~rst_i;
    assign bus.cpu_rdata_o = read_hit ? get_word(data_q[index], word) : 32'h0;
    assign bus.mem_req_o   = mem_req_q;
    assign bus.mem_we_o    = mem_we_q;
    assign bus.mem_addr_o  = mem_addr_q;
    assign bus.mem_wdata_o = mem_wdata_q;
endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
- Direct-mapped, write-back, write-allocate L1 data cache controller between the pipeline MEM stage and a slow line-wide data memory.
- Replaces the single-cycle data memory path. The MEM stage drives word requests from the EX/MEM register (ALU result as address, MemRead/MemWrite, store data).
- The controller returns load data on a hit, or stalls the whole pipeline while it services a miss through a req/ack memory handshake.

Parameters:
- NUM_LINES, 16, number of cache lines; index width = log2(NUM_LINES) = 4.
- LINE_BITS, 256, line size in bits: 32 bytes, 8 words.
- ADDR_W, 32, byte address width.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- cpu_req_i  in  1  access request (EX/MEM MemRead | MemWrite).
- cpu_we_i  in  1  1 = store, 0 = load.
- cpu_addr_i  in  32  byte address; bits[1:0] ignored (word accesses only).
- cpu_wdata_i  in  32  store data.
- cpu_rdata_o  out  32  load data; valid when cpu_req_i & !cpu_we_i & !cpu_stall_o.
- cpu_stall_o  out  1  freeze PC, IF/ID, ID/EX, EX/MEM, MEM/WB while high.
- mem_req_o  out  1  memory line request.
- mem_we_o  out  1  1 = line write-back, 0 = line fill.
- mem_addr_o  out  32  line-aligned address (bits[4:0] = 0).
- mem_wdata_o  out  256  victim line for write-back.
- mem_rdata_i  in  256  fill line; word k at bits[32k+31:32k].
- mem_ack_i  in  1  one-cycle completion pulse.

Behaviour:
- Address split: word = addr[4:2], index = addr[8:5], tag = addr[31:9] (23 bits).
- Per line: valid, dirty, tag, 256-bit data.
- hit = cpu_req_i & valid[index] & (tag[index] == addr tag).
- FSM states: IDLE, WRITEBACK, ALLOCATE.
- IDLE, read hit:
  - cpu_rdata_o = selected word, combinational, same cycle.
  - cpu_stall_o = 0.
- IDLE, write hit:
  - cpu_stall_o = 0.
  - At the clock edge, the word is replaced with cpu_wdata_i and dirty is set.
- IDLE, miss (cpu_req_i & !hit):
  - cpu_stall_o = 1 combinationally in the same cycle.
  - Next state is WRITEBACK if the victim is valid & dirty, else ALLOCATE.
- WRITEBACK:
  - Drives mem_req_o = 1, mem_we_o = 1, mem_addr_o = {victim tag, index, 5'b0}, mem_wdata_o = victim line.
  - On mem_ack_i, go to ALLOCATE.
- ALLOCATE:
  - Drives mem_req_o = 1, mem_we_o = 0, mem_addr_o = {req tag, index, 5'b0}.
  - On mem_ack_i, write mem_rdata_i into the line, set tag, valid = 1, dirty = 0, and go to IDLE.
  - The retried request then hits; a store hit sets dirty.
- mem_req_o, mem_we_o, mem_addr_o and mem_wdata_o are held stable until the ack cycle inclusive. All are derived from the state register only.
- cpu_stall_o = 1 throughout WRITEBACK and ALLOCATE, including the ack cycle.
- Clean-miss latency: stall cycles = 1 + (cycles until ack) in ALLOCATE. Data is returned in the first IDLE cycle after that.
- CPU contract: cpu_req_i, cpu_we_i, cpu_addr_i and cpu_wdata_i stay stable while cpu_stall_o = 1.
- mem_ack_i is ignored in IDLE.
- Outside IDLE, mem_ack_i with no outstanding request cannot occur; an ack is always consumed by the current state.
- Write-back is never skipped for a dirty victim, even when the pending access is a store that will overwrite the line.
- Reset:
  - State goes to IDLE; all valid and dirty bits are cleared. Tag and data arrays are not cleared.
  - mem_req_o = 0, mem_we_o = 0, mem_addr_o = 0.
  - cpu_stall_o = 0 while rst_i = 1.
  - cpu_rdata_o = 0 whenever not a read hit.
- Reset mid-WRITEBACK or mid-ALLOCATE aborts the transfer: mem_req_o is low the cycle after the reset edge, and dirty data is discarded.
- cpu_req_i = 0: no stall, no state change.

Test Plan:
- Cold read miss: reset; read 0x0000_0048; ALLOCATE addr 0x40; ack after 3 cycles with word k = 0xA0+k. Required: stall for 4 cycles, then cpu_rdata_o = 0xA2, mem_we_o = 0 throughout.
- Write hit: write 0x48 = 0xDEADBEEF, then read 0x48. Required: no stall, no mem_req_o, read returns 0xDEADBEEF.
- Dirty eviction: read 0x248 (index 2, tag 1). Required: WRITEBACK first with addr 0x40 and mem_wdata_o word2 = 0xDEADBEEF, other words 0xA0+k; then ALLOCATE addr 0x240; final rdata = word2 of the fill.
- Clean eviction: read 0x048 again after the previous test. Required: ALLOCATE only (line 0x240 is clean), no mem_we_o = 1 cycle.
- Slow memory: ack delayed 10 cycles. Required: mem_req_o, mem_addr_o and cpu_stall_o held constant for all 10 cycles; a stray ack in IDLE causes no state change.
- Reset mid-ALLOCATE: assert rst_i one cycle. Required: mem_req_o = 0 the next cycle; a read of 0x48 then misses again.
